// File: rtl/imm_gen_pkg.sv
// Shared opcode and format constants for the registered immediate generator.
package imm_gen_pkg;

  localparam int unsigned FMT_W = 3;

  localparam logic [FMT_W-1:0] FMT_R    = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I    = 3'd1;
  localparam logic [FMT_W-1:0] FMT_S    = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B    = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U    = 3'd4;
  localparam logic [FMT_W-1:0] FMT_J    = 3'd5;
  localparam logic [FMT_W-1:0] FMT_CSR  = 3'd6;
  localparam logic [FMT_W-1:0] FMT_NONE = 3'd7;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decoder: instr -> {imm, fmt, illegal}, extended to XLEN.
// SYSTEM (CSR) immediates are decoded only when IMMGEN_CSR_EN is defined.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]      instr_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [FMT_W-1:0] fmt_o,
  output logic             illegal_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        sgn;
  logic [31:0] imm32;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign sgn    = instr_i[31];

  always_comb begin
    imm32     = '0;
    fmt_o     = FMT_NONE;
    illegal_o = 1'b0;
    unique case (opcode)
      OPC_LOAD, OPC_JALR: begin
        fmt_o = FMT_I;
        imm32 = {{20{sgn}}, instr_i[31:20]};
      end
      OPC_OPIMM, OPC_OPIMM32: begin
        fmt_o = FMT_I;
        // Shifts carry a zero-extended shamt; only RV64 OP-IMM has the 6-bit form.
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          if (XLEN == 64 && opcode == OPC_OPIMM) imm32 = {26'b0, instr_i[25:20]};
          else                                   imm32 = {27'b0, instr_i[24:20]};
        end else begin
          imm32 = {{20{sgn}}, instr_i[31:20]};
        end
      end
      OPC_STORE: begin
        fmt_o = FMT_S;
        imm32 = {{20{sgn}}, instr_i[31:25], instr_i[11:7]};
      end
      OPC_BRANCH: begin
        fmt_o = FMT_B;
        imm32 = {{19{sgn}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_o = FMT_U;
        imm32 = {instr_i[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt_o = FMT_J;
        imm32 = {{11{sgn}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      end
      OPC_OP, OPC_OP32: begin
        fmt_o = FMT_R;
      end
`ifdef IMMGEN_CSR_EN
      OPC_SYSTEM: begin
        unique case (funct3)
          3'b101, 3'b110, 3'b111: begin
            fmt_o = FMT_CSR;
            imm32 = {27'b0, instr_i[19:15]};
          end
          3'b001, 3'b010, 3'b011: begin
            fmt_o = FMT_I;
            imm32 = {20'b0, instr_i[31:20]};
          end
          default: illegal_o = 1'b1;
        endcase
      end
`endif
      default: illegal_o = 1'b1;
    endcase
  end

  // Zero-extended cases keep bit 31 clear, so one sign extension covers every format.
  assign imm_o = {{(XLEN - 31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode stage with valid/ready output register and skid slot.
// Optional CSR immediates via IMMGEN_CSR_EN (handled in imm_decode).
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [FMT_W-1:0] out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [FMT_W-1:0] fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t dec_entry;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q;
  logic   accept;
  logic   out_free;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instr_i  (in_instr),
    .imm_o    (dec_entry.imm),
    .fmt_o    (dec_entry.fmt),
    .illegal_o(dec_entry.illegal)
  );
  assign dec_entry.tag = in_tag;

  assign accept   = in_valid & in_ready_q;
  assign out_free = ~out_valid_q | out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      // in_ready is low whenever the skid slot is full, so accept and skid refill never overlap.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= ~skid_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;
  assign out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table at XLEN=32/64 plus handshake, flush and reset.
module tb_imm_gen_pipe;

  localparam int TAG_W = 5;
  localparam int NV    = 17;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, out_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;

  logic             in_ready, out_valid, out_illegal;
  logic [31:0]      out_imm;
  logic [2:0]       out_fmt;
  logic [TAG_W-1:0] out_tag;

  logic             in_ready64, out_valid64, out_illegal64;
  logic [63:0]      out_imm64;
  logic [2:0]       out_fmt64;
  logic [TAG_W-1:0] out_tag64;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm    (out_imm),
    .out_fmt    (out_fmt),
    .out_illegal(out_illegal),
    .out_tag    (out_tag)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready64),
    .in_instr   (in_instr),
    .in_tag     (in_tag),
    .out_valid  (out_valid64),
    .out_ready  (out_ready),
    .out_imm    (out_imm64),
    .out_fmt    (out_fmt64),
    .out_illegal(out_illegal64),
    .out_tag    (out_tag64)
  );

  typedef struct {
    logic [31:0]      instr;
    logic [TAG_W-1:0] tag;
    logic [31:0]      imm32;
    logic [63:0]      imm64;
    logic [2:0]       fmt;
    logic             illegal;
  } vec_t;

  vec_t vecs[NV];

  function automatic vec_t mk(input logic [31:0] instr, input logic [TAG_W-1:0] tag,
                              input logic [31:0] imm32, input logic [63:0] imm64,
                              input logic [2:0] fmt, input logic illegal);
    vec_t v;
    v.instr = instr; v.tag = tag; v.imm32 = imm32; v.imm64 = imm64;
    v.fmt = fmt; v.illegal = illegal;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(32'hFFC12083, 5'd1,  32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd1, 1'b0); // lw -4
    vecs[1]  = mk(32'hFE112E23, 5'd2,  32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0); // sw -4
    vecs[2]  = mk(32'hFE000CE3, 5'd3,  32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 3'd3, 1'b0); // beq -8
    vecs[3]  = mk(32'h123452B7, 5'd4,  32'h12345000, 64'h00000000_12345000, 3'd4, 1'b0); // lui
    vecs[4]  = mk(32'h800000B7, 5'd5,  32'h80000000, 64'hFFFFFFFF_80000000, 3'd4, 1'b0); // lui neg
    vecs[5]  = mk(32'h0000007F, 5'h15, 32'h00000000, 64'h0,                 3'd7, 1'b1); // illegal
    vecs[6]  = mk(32'h001000EF, 5'd7,  32'h00000800, 64'h00000000_00000800, 3'd5, 1'b0); // jal +2048
    vecs[7]  = mk(32'hFFDFF0EF, 5'd8,  32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd5, 1'b0); // jal -4
    vecs[8]  = mk(32'h7FF00093, 5'd9,  32'h000007FF, 64'h00000000_000007FF, 3'd1, 1'b0); // addi 2047
    vecs[9]  = mk(32'h01F09093, 5'd10, 32'h0000001F, 64'h00000000_0000001F, 3'd1, 1'b0); // slli 31
    vecs[10] = mk(32'h4050D093, 5'd11, 32'h00000005, 64'h00000000_00000005, 3'd1, 1'b0); // srai 5
    vecs[11] = mk(32'h02109093, 5'd12, 32'h00000001, 64'h00000000_00000021, 3'd1, 1'b0); // slli 33
    vecs[12] = mk(32'h0210909B, 5'd13, 32'h00000001, 64'h00000000_00000001, 3'd1, 1'b0); // slliw
    vecs[13] = mk(32'h002081B3, 5'd14, 32'h00000000, 64'h0,                 3'd0, 1'b0); // add
    vecs[14] = mk(32'hFFFFF117, 5'd16, 32'hFFFFF000, 64'hFFFFFFFF_FFFFF000, 3'd4, 1'b0); // auipc
`ifdef IMMGEN_CSR_EN
    vecs[15] = mk(32'h3002D073, 5'd17, 32'h00000005, 64'h5,                 3'd6, 1'b0); // csrrwi
    vecs[16] = mk(32'h30029073, 5'd18, 32'h00000300, 64'h300,               3'd1, 1'b0); // csrrw
`else
    vecs[15] = mk(32'h3002D073, 5'd17, 32'h00000000, 64'h0,                 3'd7, 1'b1);
    vecs[16] = mk(32'h30029073, 5'd18, 32'h00000000, 64'h0,                 3'd7, 1'b1);
`endif

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_tag = '0;
    tick; tick;
    check("rst out_valid", out_valid, 0);
    check("rst out_imm", out_imm, 0);
    check("rst out_fmt", out_fmt, 0);
    check("rst out_illegal", out_illegal, 0);
    check("rst out_tag", out_tag, 0);
    check("rst in_ready", in_ready, 0);
    reset = 1'b0;
    tick;
    check("post-rst in_ready", in_ready, 1);

    // Back-to-back decode table, one accepted instruction per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; in_instr = vecs[i].instr; in_tag = vecs[i].tag;
      check($sformatf("vec%0d in_ready", i), in_ready, 1);
      tick;
      check($sformatf("vec%0d out_valid", i), out_valid, 1);
      check($sformatf("vec%0d imm32", i), out_imm, vecs[i].imm32);
      check($sformatf("vec%0d imm64", i), out_imm64, vecs[i].imm64);
      check($sformatf("vec%0d fmt", i), out_fmt, vecs[i].fmt);
      check($sformatf("vec%0d illegal", i), out_illegal, vecs[i].illegal);
      check($sformatf("vec%0d tag", i), out_tag, vecs[i].tag);
    end
    in_valid = 1'b0;
    tick;
    check("idle out_valid", out_valid, 0);

    // Backpressure: three offered, two taken, then drained in order without gaps.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h123452B7;
    in_tag = 5'd1; tick;
    check("bp1 out_tag", out_tag, 1);
    check("bp1 in_ready", in_ready, 1);
    in_tag = 5'd2; tick;
    check("bp2 in_ready", in_ready, 0);
    check("bp2 out_tag", out_tag, 1);
    in_tag = 5'd3; tick;
    check("bp3 in_ready", in_ready, 0);
    check("bp3 out_valid", out_valid, 1);
    check("bp3 out_tag stable", out_tag, 1);
    check("bp3 out_imm stable", out_imm, 32'h12345000);
    out_ready = 1'b1; tick;
    check("drain1 out_tag", out_tag, 2);
    check("drain1 out_valid", out_valid, 1);
    check("drain1 in_ready", in_ready, 1);
    tick;
    check("drain2 out_tag", out_tag, 3);
    check("drain2 out_valid", out_valid, 1);
    in_valid = 1'b0; tick;
    check("drain3 out_valid", out_valid, 0);

    // Flush with output and skid both occupied.
    out_ready = 1'b0; in_valid = 1'b1;
    in_tag = 5'd4; tick;
    in_tag = 5'd5; tick;
    check("fl pre in_ready", in_ready, 0);
    flush = 1'b1; in_tag = 5'd6; tick;
    flush = 1'b0; in_valid = 1'b0;
    check("fl out_valid", out_valid, 0);
    check("fl in_ready", in_ready, 1);
    out_ready = 1'b1; tick;
    check("fl after out_valid", out_valid, 0);

    // Flush discards an input handshaking in the same cycle.
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 5'd7; tick;
    flush = 1'b1; in_tag = 5'd8; tick;
    flush = 1'b0; in_valid = 1'b0;
    check("fl2 out_valid", out_valid, 0);
    check("fl2 in_ready", in_ready, 1);
    out_ready = 1'b1; tick;
    check("fl2 after out_valid", out_valid, 0);

    // Reset mid-stream; reset wins over flush.
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 5'd9; tick;
    in_tag = 5'd10; tick;
    reset = 1'b1; flush = 1'b1; tick;
    check("mrst out_valid", out_valid, 0);
    check("mrst out_imm", out_imm, 0);
    check("mrst out_tag", out_tag, 0);
    check("mrst in_ready", in_ready, 0);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; tick;
    check("mrst release in_ready", in_ready, 1);
    check("mrst release out_valid", out_valid, 0);
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFE000CE3; in_tag = 5'd11; tick;
    in_valid = 1'b0;
    check("mrst resume imm", out_imm, 32'hFFFFFFF8);
    check("mrst resume tag", out_tag, 11);
    tick;
    check("mrst resume drained", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
